// File: rtl/spi_sample_sequencer_pkg.sv
// Shared constants for the SPI amplifier/ADC sample sequencer:
// FSM state encodings, AMP_ADC select encodings and parameter defaults.
package spi_sample_sequencer_pkg;

  // Sequencer states, kept as plain 3-bit constants for older tools
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_AMP_REQ  = 3'd1;
  localparam logic [2:0] ST_AMP_WAIT = 3'd2;
  localparam logic [2:0] ST_ARMED    = 3'd3;
  localparam logic [2:0] ST_ADC_REQ  = 3'd4;
  localparam logic [2:0] ST_ADC_WAIT = 3'd5;
  localparam logic [2:0] ST_CAPTURE  = 3'd6;
  localparam logic [2:0] ST_ERROR    = 3'd7;

  // AMP_ADC line encodings toward the segment
  localparam logic SEL_AMP = 1'b1;
  localparam logic SEL_ADC = 1'b0;

  // Parameter defaults
  localparam int DEF_SAMPLE_DIV = 2000;
  localparam int DEF_TIMEOUT    = 4095;
  localparam int DEF_OVR_W      = 8;

  // States in which Init is driven high toward the segment
  function automatic logic drives_init(input logic [2:0] st);
    return (st == ST_AMP_REQ) || (st == ST_AMP_WAIT) ||
           (st == ST_ADC_REQ) || (st == ST_ADC_WAIT);
  endfunction

  // States in which a segment transaction is in flight
  function automatic logic is_busy_state(input logic [2:0] st);
    return drives_init(st) || (st == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/spi_sample_sequencer_sample_tick_gen.sv
// Sample-period tick generator: counts 0..DIV-1 while enabled and emits a
// single-cycle tick on the wrap cycle. A synchronous clear restarts the period.
module sample_tick_gen #(
  parameter int DIV = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear wins, otherwise advance and wrap while enabled
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = en && !clr && (count_q == LAST);

endmodule

// File: rtl/spi_sample_sequencer.sv
// Sequencer for the SPI amplifier/ADC segment: programs the amplifier once
// after start, then runs periodic ADC conversions through the
// Init / AMP_ADC / Init_Done handshake, capturing each result. Also handles
// amplifier reprogram requests, missed sample ticks and stalled transactions.
module spi_sample_sequencer
  import spi_sample_sequencer_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int OVR_W      = DEF_OVR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             amp_req,
  output logic             seg_init,
  output logic             seg_amp_adc,
  input  logic             seg_init_done,
  input  logic [7:0]       seg_data,
  output logic [7:0]       sample,
  output logic             sample_valid,
  output logic             busy,
  output logic             running,
  output logic             overrun,
  output logic [OVR_W-1:0] ovr_count,
  output logic             timeout_err
);

  localparam int TOW = $clog2(TIMEOUT + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);

  logic [2:0]       state_q,       state_d;
  logic             amp_adc_q,     amp_adc_d;
  logic             running_q,     running_d;
  logic [7:0]       sample_q,      sample_d;
  logic             stop_pend_q,   stop_pend_d;
  logic             amp_pend_q,    amp_pend_d;
  logic             overrun_q,     overrun_d;
  logic [OVR_W-1:0] ovr_cnt_q,     ovr_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic [TOW-1:0]   to_cnt_q,      to_cnt_d;

  logic tick;
  logic start_accept;
  logic stop_now;
  logic amp_now;
  logic tick_used;
  logic tick_missed;

  // Stop beats start when both arrive together in IDLE
  assign start_accept = (state_q == ST_IDLE) && start && !stop;
  assign stop_now     = stop_pend_q || stop;
  assign amp_now      = amp_pend_q  || amp_req;

  sample_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (running_q),
    .clr  (start_accept),
    .tick (tick)
  );

  // FSM next state plus pending-request, overrun and timeout bookkeeping
  always_comb begin
    state_d       = state_q;
    amp_adc_d     = amp_adc_q;
    running_d     = running_q;
    sample_d      = sample_q;
    stop_pend_d   = stop_pend_q;
    amp_pend_d    = amp_pend_q;
    overrun_d     = overrun_q;
    ovr_cnt_d     = ovr_cnt_q;
    timeout_err_d = timeout_err_q;
    to_cnt_d      = to_cnt_q;
    tick_used     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_accept) begin
          state_d       = ST_AMP_REQ;
          amp_adc_d     = SEL_AMP;
          running_d     = 1'b1;
          overrun_d     = 1'b0;
          ovr_cnt_d     = '0;
          timeout_err_d = 1'b0;
        end
      end
      ST_AMP_REQ: begin
        state_d  = ST_AMP_WAIT;
        to_cnt_d = '0;
      end
      ST_AMP_WAIT: begin
        if (seg_init_done) begin
          state_d    = ST_ARMED;
          amp_pend_d = 1'b0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d       = ST_ERROR;
          timeout_err_d = 1'b1;
          running_d     = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end
      ST_ARMED: begin
        if (stop_now) begin
          state_d   = ST_IDLE;
          running_d = 1'b0;
        end else if (amp_now) begin
          state_d   = ST_AMP_REQ;
          amp_adc_d = SEL_AMP;
        end else if (tick) begin
          state_d   = ST_ADC_REQ;
          amp_adc_d = SEL_ADC;
          tick_used = 1'b1;
        end
      end
      ST_ADC_REQ: begin
        state_d  = ST_ADC_WAIT;
        to_cnt_d = '0;
      end
      ST_ADC_WAIT: begin
        if (seg_init_done) begin
          state_d  = ST_CAPTURE;
          sample_d = seg_data;
        end else if (to_cnt_q == TO_LAST) begin
          state_d       = ST_ERROR;
          timeout_err_d = 1'b1;
          running_d     = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + TOW'(1);
        end
      end
      ST_CAPTURE: begin
        state_d = ST_ARMED;
      end
      ST_ERROR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        running_d = 1'b0;
      end
    endcase

    // Requests are only remembered while streaming
    if (running_q && stop) begin
      stop_pend_d = 1'b1;
    end
    if (running_q && amp_req) begin
      amp_pend_d = 1'b1;
    end

    // A tick that does not launch a conversion is dropped and counted,
    // except when the sequencer is leaving ARMED because of a stop
    tick_missed = tick && !tick_used &&
                  !((state_q == ST_ARMED) && stop_now);
    if (tick_missed) begin
      overrun_d = 1'b1;
      if (ovr_cnt_q != {OVR_W{1'b1}}) begin
        ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
      end
    end

    // Returning to IDLE forgets any outstanding requests
    if (state_d == ST_IDLE) begin
      stop_pend_d = 1'b0;
      amp_pend_d  = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      amp_adc_q     <= 1'b0;
      running_q     <= 1'b0;
      sample_q      <= 8'h00;
      stop_pend_q   <= 1'b0;
      amp_pend_q    <= 1'b0;
      overrun_q     <= 1'b0;
      ovr_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      amp_adc_q     <= amp_adc_d;
      running_q     <= running_d;
      sample_q      <= sample_d;
      stop_pend_q   <= stop_pend_d;
      amp_pend_q    <= amp_pend_d;
      overrun_q     <= overrun_d;
      ovr_cnt_q     <= ovr_cnt_d;
      timeout_err_q <= timeout_err_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign seg_init     = drives_init(state_q);
  assign seg_amp_adc  = amp_adc_q;
  assign busy         = is_busy_state(state_q);
  assign sample_valid = (state_q == ST_CAPTURE);
  assign sample       = sample_q;
  assign running      = running_q;
  assign overrun      = overrun_q;
  assign ovr_count    = ovr_cnt_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_spi_sample_sequencer.sv
// Directed testbench for spi_sample_sequencer with a simple segment model
// (programmable Init_Done latency, optional hang) and a negedge monitor.
module tb_spi_sample_sequencer;

  localparam int SDIV = 16;
  localparam int TMO  = 50;
  localparam int OW   = 8;
  localparam int MAXN = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          amp_req = 1'b0;
  logic          seg_init;
  logic          seg_amp_adc;
  logic          seg_init_done = 1'b0;
  logic [7:0]    seg_data = 8'h00;
  logic [7:0]    sample;
  logic          sample_valid;
  logic          busy;
  logic          running;
  logic          overrun;
  logic [OW-1:0] ovr_count;
  logic          timeout_err;

  int n_cmp = 0;
  int n_bad = 0;

  int  model_lat  = 5;
  bit  model_hang = 1'b0;
  bit  model_clr  = 1'b0;
  int  m_cnt      = 0;
  int  adc_idx    = 0;
  logic [7:0] data_tbl [0:3] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};

  logic       init_prev = 1'b0;
  logic       txn_sel [0:MAXN-1];
  int         txn_n = 0;
  logic [7:0] samp_val [0:MAXN-1];
  int         samp_t [0:MAXN-1];
  int         samp_n = 0;
  int         cyc = 0;

  spi_sample_sequencer #(
    .SAMPLE_DIV (SDIV),
    .TIMEOUT    (TMO),
    .OVR_W      (OW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .amp_req       (amp_req),
    .seg_init      (seg_init),
    .seg_amp_adc   (seg_amp_adc),
    .seg_init_done (seg_init_done),
    .seg_data      (seg_data),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .running       (running),
    .overrun       (overrun),
    .ovr_count     (ovr_count),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time captured samples
  always @(posedge clk) cyc <= cyc + 1;

  // Segment model: raises Init_Done model_lat cycles after Init, one cycle wide
  always @(posedge clk) begin
    if (model_clr) adc_idx <= 0;
    if (rst || !seg_init || seg_init_done) begin
      m_cnt         <= 0;
      seg_init_done <= 1'b0;
    end else if (!model_hang) begin
      if (m_cnt == model_lat - 1) begin
        seg_init_done <= 1'b1;
        seg_data      <= seg_amp_adc ? 8'hFF : data_tbl[adc_idx % 4];
        if (!seg_amp_adc && !model_clr) adc_idx <= adc_idx + 1;
        m_cnt <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Monitor: records each transaction's AMP_ADC and each captured sample
  always @(negedge clk) begin
    if (seg_init && !init_prev && txn_n < MAXN) begin
      txn_sel[txn_n] = seg_amp_adc;
      txn_n = txn_n + 1;
    end
    init_prev = seg_init;
    if (sample_valid && samp_n < MAXN) begin
      samp_val[samp_n] = sample;
      samp_t[samp_n]   = cyc;
      samp_n = samp_n + 1;
    end
  end

  task automatic clear_model();
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_samples(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (samp_n >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_txns(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (txn_n >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (!running && !busy) begin ok = 1'b1; break; end
    end
  endtask

  // Lands one cycle into ADC_WAIT of the next conversion
  task automatic wait_adc_wait(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (seg_init && !seg_amp_adc) begin ok = 1'b1; break; end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    bit ok;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({seg_init, seg_amp_adc, busy, running, sample_valid, overrun, timeout_err} !== 7'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_flags: got %b expected 0000000",
               {seg_init, seg_amp_adc, busy, running, sample_valid, overrun, timeout_err});
    end
    n_cmp++;
    if (sample !== 8'h00 || ovr_count !== 8'h00) begin
      n_bad++;
      $display("[TB] FAIL reset_values: got sample=%h ovr=%h expected 00/00", sample, ovr_count);
    end
    rst = 1'b0;
    model_lat = 5;
    clear_model();
    pulse_start();
    wait_samples(samp_n + 1, 60, ok);
    n_cmp++;
    if (ok !== 1'b1 || sample !== 8'hA5) begin
      n_bad++;
      $display("[TB] FAIL reset_first_sample: got ok=%0d sample=%h expected 1/a5", ok, sample);
    end
    wait_adc_wait(40, ok);
    n_cmp++;
    if (ok !== 1'b1 || seg_init !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_reach_wait: got ok=%0d init=%b expected 1/1", ok, seg_init);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({seg_init, busy, running, sample_valid, overrun, timeout_err} !== 6'b0 ||
        sample !== 8'h00 || ovr_count !== 8'h00) begin
      n_bad++;
      $display("[TB] FAIL reset_mid_wait: got init=%b busy=%b run=%b smp=%h ovr=%h to=%b expected all 0",
               seg_init, busy, running, sample, ovr_count, timeout_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stream();
    bit ok;
    int bt, bs;
    clear_model();
    model_lat = 5;
    bt = txn_n;
    bs = samp_n;
    pulse_start();
    wait_samples(bs + 2, 80, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL stream_timeout: got %0d samples expected 2", samp_n - bs);
    end else begin
      n_cmp++;
      if (txn_n - bt < 3 || txn_sel[bt] !== 1'b1 || txn_sel[bt+1] !== 1'b0 || txn_sel[bt+2] !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL stream_txn_order: got n=%0d sel=%b%b%b expected >=3 / 100",
                 txn_n - bt, txn_sel[bt], txn_sel[bt+1], txn_sel[bt+2]);
      end
      n_cmp++;
      if (samp_val[bs] !== 8'hA5 || samp_val[bs+1] !== 8'h3C) begin
        n_bad++;
        $display("[TB] FAIL stream_data: got %h %h expected a5 3c", samp_val[bs], samp_val[bs+1]);
      end
      n_cmp++;
      if (samp_t[bs+1] - samp_t[bs] !== SDIV) begin
        n_bad++;
        $display("[TB] FAIL stream_period: got %0d expected %0d", samp_t[bs+1] - samp_t[bs], SDIV);
      end
      n_cmp++;
      if (overrun !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL stream_no_overrun: got %b expected 0", overrun);
      end
    end
    pulse_stop();
    wait_idle(60, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL stream_stop_idle: got running=%b expected 0", running);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int bs;
    clear_model();
    model_lat = 20;
    bs = samp_n;
    pulse_start();
    wait_samples(bs + 1, 100, ok);
    n_cmp++;
    if (ok !== 1'b1 || samp_val[bs] !== 8'hA5 || ovr_count !== 8'd2 || overrun !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL overrun_first: got ok=%0d smp=%h ovr_cnt=%0d ovr=%b expected 1/a5/2/1",
               ok, samp_val[bs], ovr_count, overrun);
    end
    wait_samples(bs + 2, 60, ok);
    n_cmp++;
    if (ok !== 1'b1 || samp_val[bs+1] !== 8'h3C || ovr_count !== 8'd3) begin
      n_bad++;
      $display("[TB] FAIL overrun_second: got ok=%0d smp=%h ovr_cnt=%0d expected 1/3c/3",
               ok, samp_val[bs+1], ovr_count);
    end
    pulse_stop();
    wait_idle(80, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL overrun_stop_idle: got running=%b expected 0", running);
    end
    model_lat = 5;
  endtask

  task automatic test_amp_req();
    bit ok;
    int bt, bs;
    clear_model();
    model_lat = 5;
    bt = txn_n;
    bs = samp_n;
    pulse_start();
    wait_adc_wait(60, ok);
    amp_req = 1'b1;
    @(negedge clk);
    amp_req = 1'b0;
    wait_samples(bs + 1, 40, ok);
    n_cmp++;
    if (ok !== 1'b1 || samp_val[bs] !== 8'hA5) begin
      n_bad++;
      $display("[TB] FAIL amp_capture: got ok=%0d smp=%h expected 1/a5", ok, samp_val[bs]);
    end
    wait_txns(bt + 4, 60, ok);
    n_cmp++;
    if (ok !== 1'b1 || txn_sel[bt+2] !== 1'b1 || txn_sel[bt+3] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL amp_reprogram: got ok=%0d sel=%b%b expected 1/10",
               ok, txn_sel[bt+2], txn_sel[bt+3]);
    end
    wait_samples(bs + 2, 40, ok);
    n_cmp++;
    if (ok !== 1'b1 || samp_val[bs+1] !== 8'h3C) begin
      n_bad++;
      $display("[TB] FAIL amp_next_sample: got ok=%0d smp=%h expected 1/3c", ok, samp_val[bs+1]);
    end
    pulse_stop();
    wait_idle(60, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL amp_stop_idle: got running=%b expected 0", running);
    end
  endtask

  task automatic test_timeout();
    clear_model();
    model_hang = 1'b1;
    pulse_start();
    repeat (50) @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b0 || seg_init !== 1'b1 || seg_amp_adc !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL timeout_early: got to=%b init=%b sel=%b expected 0/1/1",
               timeout_err, seg_init, seg_amp_adc);
    end
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b1 || seg_init !== 1'b0 || running !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL timeout_fire: got to=%b init=%b run=%b expected 1/0/0",
               timeout_err, seg_init, running);
    end
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || running !== 1'b0 ||
        overrun !== 1'b1 || ovr_count !== 8'd3) begin
      n_bad++;
      $display("[TB] FAIL timeout_idle: got to=%b busy=%b run=%b ovr=%b cnt=%0d expected 1/0/0/1/3",
               timeout_err, busy, running, overrun, ovr_count);
    end
    model_hang = 1'b0;
  endtask

  task automatic test_stop();
    bit ok;
    int bs, bt;
    clear_model();
    model_lat = 5;
    bs = samp_n;
    pulse_start();
    n_cmp++;
    if (timeout_err !== 1'b0 || overrun !== 1'b0 || ovr_count !== 8'd0 || running !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL stop_start_clears: got to=%b ovr=%b cnt=%0d run=%b expected 0/0/0/1",
               timeout_err, overrun, ovr_count, running);
    end
    wait_adc_wait(60, ok);
    pulse_stop();
    wait_samples(bs + 1, 40, ok);
    n_cmp++;
    if (ok !== 1'b1 || samp_val[bs] !== 8'hA5) begin
      n_bad++;
      $display("[TB] FAIL stop_completes: got ok=%0d smp=%h expected 1/a5", ok, samp_val[bs]);
    end
    @(negedge clk);
    n_cmp++;
    if (running !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL stop_armed: got run=%b busy=%b expected 1/0", running, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (running !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL stop_idle: got run=%b expected 0", running);
    end
    bt = txn_n;
    repeat (40) @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (running !== 1'b0 || busy !== 1'b0 || txn_n !== bt) begin
      n_bad++;
      $display("[TB] FAIL stop_start_same_cycle: got run=%b busy=%b txns=%0d expected 0/0/0",
               running, busy, txn_n - bt);
    end
  endtask

  initial begin
    $display("[TB] spi_sample_sequencer directed bench, SAMPLE_DIV=%0d TIMEOUT=%0d", SDIV, TMO);
    test_reset();
    test_stream();
    test_overrun();
    test_amp_req();
    test_timeout();
    test_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
